// File: rtl/seg_data_driver.sv
// Segment-data driver for a multiplexed 4-digit 7-segment display.
// Holds a double-buffered display value: writes land in a pending buffer
// and are copied to the shown buffer at a frame boundary (or on the next
// cycle when FRAME_COMMIT=0), so a digit never mixes old and new data.
//
// state | meaning
// IDLE  | no pending value, wr_ready=1, a write is captured into pending
// PEND  | pending value waiting for commit, wr_ready=0, writes ignored
module seg_data_driver #(
  parameter bit LZ_BLANK     = 1'b1,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit FRAME_COMMIT = 1'b1
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [2:0]  sel,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  output logic        wr_ready,
  output logic [7:0]  seg,
  output logic        frame
);

  localparam logic [7:0] SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t      state;
  logic [15:0] shown_val;
  logic [15:0] pend_val;
  logic [3:0]  shown_dp;
  logic [3:0]  pend_dp;
  logic [2:0]  sel_q;
  logic        boundary;
  logic [1:0]  digit;
  logic [3:0]  nib;
  logic        lead_zero;
  logic [6:0]  glyph;
  logic [7:0]  seg_lit;
  logic [7:0]  seg_next;

  // A frame ends when the scanner enters select 0 from any other select.
  assign boundary = (sel == 3'd0) && (sel_q != 3'd0);
  assign digit    = ~sel[1:0];

  // Pick the active nibble and flag it if it and every higher nibble are zero.
  always_comb begin
    nib       = shown_val[3:0];
    lead_zero = 1'b0;
    case (digit)
      2'd3: begin
        nib       = shown_val[15:12];
        lead_zero = (shown_val[15:12] == 4'h0);
      end
      2'd2: begin
        nib       = shown_val[11:8];
        lead_zero = (shown_val[15:8] == 8'h00);
      end
      2'd1: begin
        nib       = shown_val[7:4];
        lead_zero = (shown_val[15:4] == 12'h000);
      end
      default: begin
        nib       = shown_val[3:0];
        lead_zero = 1'b0;
      end
    endcase
  end

  // Hex to segments, active-high, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    glyph = 7'h00;
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  end

  // Blank inactive selects and leading zeros (a set dp keeps the digit lit); polarity last.
  always_comb begin
    seg_lit = 8'h00;
    if (sel[2] && !(LZ_BLANK && lead_zero && !shown_dp[digit])) begin
      seg_lit = {shown_dp[digit], glyph};
    end
    seg_next = SEG_ACT_LOW ? ~seg_lit : seg_lit;
  end

  // Write handshake: capture into pending, then commit to the shown buffer.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ready  <= 1'b1;
      pend_val  <= 16'h0000;
      pend_dp   <= 4'h0;
      shown_val <= 16'h0000;
      shown_dp  <= 4'h0;
    end else if (state == IDLE) begin
      if (wr_en) begin
        pend_val <= wr_data;
        pend_dp  <= wr_dp;
        state    <= PEND;
        wr_ready <= 1'b0;
      end
    end else begin
      if (!FRAME_COMMIT || boundary) begin
        shown_val <= pend_val;
        shown_dp  <= pend_dp;
        state     <= IDLE;
        wr_ready  <= 1'b1;
      end
    end
  end

  // Register the segment bus, the previous select and the frame pulse.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      seg   <= SEG_OFF;
      sel_q <= 3'd0;
      frame <= 1'b0;
    end else begin
      seg   <= seg_next;
      sel_q <= sel;
      frame <= boundary;
    end
  end

endmodule

// File: tb/tb_seg_data_driver.sv
// Bench for seg_data_driver: directed scenarios with literal expectations
// plus randomized scanning/writes checked through a scoreboard queue fed
// by a behavioural display model.
module tb_seg_data_driver;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  sel = 3'd0;
  logic        wr_en = 1'b0;
  logic        wr_en2 = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic [3:0]  wr_dp = 4'h0;
  logic        wr_ready, wr_ready2, frame, frame2;
  logic [7:0]  seg, seg2;

  seg_data_driver dut (
    .clock(clock), .rst(rst), .sel(sel), .wr_en(wr_en), .wr_data(wr_data),
    .wr_dp(wr_dp), .wr_ready(wr_ready), .seg(seg), .frame(frame)
  );

  seg_data_driver #(.FRAME_COMMIT(1'b0)) dut_nc (
    .clock(clock), .rst(rst), .sel(sel), .wr_en(wr_en2), .wr_data(wr_data),
    .wr_dp(wr_dp), .wr_ready(wr_ready2), .seg(seg2), .frame(frame2)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] seg;
    logic       frame;
    logic       ready;
  } exp_t;

  exp_t q[$];
  bit   mon_en = 1'b0;

  // behavioural model state
  logic [15:0] m_val, m_pval;
  logic [3:0]  m_dp, m_pdp;
  bit          m_idle;
  logic [2:0]  m_selq;

  logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Active-low segment byte the display should show for select s.
  function automatic logic [7:0] exp_seg(input logic [2:0] s, input logic [15:0] v,
                                         input logic [3:0] d);
    int k;
    logic [3:0] n;
    if (s < 3'd4) return 8'hFF;
    k = 7 - int'(s);
    n = v[4*k +: 4];
    if (k != 0 && !d[k] && (v >> (4*k)) == 16'h0000) return 8'hFF;
    return ~{d[k], hex7[n]};
  endfunction

  task automatic model_reset();
    m_val = 16'h0; m_pval = 16'h0; m_dp = 4'h0; m_pdp = 4'h0;
    m_idle = 1'b1; m_selq = 3'd0;
  endtask

  // Drive one cycle of inputs and queue what the DUT must show after that edge.
  task automatic step(input logic [2:0] s, input logic we = 1'b0,
                      input logic [15:0] d = 16'h0, input logic [3:0] dp = 4'h0,
                      input logic we2 = 1'b0);
    exp_t e;
    bit bnd;
    @(negedge clock);
    sel = s; wr_en = we; wr_data = d; wr_dp = dp; wr_en2 = we2;
    e.seg = exp_seg(s, m_val, m_dp);
    bnd = (s == 3'd0) && (m_selq != 3'd0);
    e.frame = bnd;
    if (m_idle) begin
      if (we) begin m_pval = d; m_pdp = dp; m_idle = 1'b0; end
    end else if (bnd) begin
      m_val = m_pval; m_dp = m_pdp; m_idle = 1'b1;
    end
    m_selq = s;
    e.ready = m_idle;
    q.push_back(e);
  endtask

  // Write during a scan with a conflicting write held in PEND; commits on the closing 0.
  task automatic frame_write(input logic [15:0] d, input logic [3:0] dp);
    step(3'd4, 1'b1, d, dp);
    step(3'd5, 1'b1, ~d, ~dp);
    chk("ready_after_write", 16'(wr_ready), 16'h0);
    step(3'd6, 1'b1, ~d, ~dp);
    step(3'd7, 1'b1, ~d, ~dp);
    step(3'd0, 1'b1, ~d, ~dp);
  endtask

  // Scan one frame right after a boundary and check each digit literally.
  task automatic scan_check(input logic [7:0] e3, input logic [7:0] e2,
                            input logic [7:0] e1, input logic [7:0] e0);
    step(3'd4);
    chk("frame_after_boundary", 16'(frame), 16'h1);
    step(3'd5); chk("seg_digit3", 16'(seg), 16'(e3));
    step(3'd6); chk("seg_digit2", 16'(seg), 16'(e2));
    step(3'd7); chk("seg_digit1", 16'(seg), 16'(e1));
    step(3'd0); chk("seg_digit0", 16'(seg), 16'(e0));
  endtask

  // Scoreboard monitor: one expectation per clock edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (mon_en && !rst && q.size() != 0) begin
      e = q.pop_front();
      chk("sb_seg", 16'(seg), 16'(e.seg));
      chk("sb_frame", 16'(frame), 16'(e.frame));
      chk("sb_ready", 16'(wr_ready), 16'(e.ready));
    end
  end

  initial begin
    logic [2:0] s, last_s;
    logic [15:0] d;
    logic [3:0] dp;
    int pos;
    logic [2:0] scan [5];
    scan[0] = 3'd4; scan[1] = 3'd5; scan[2] = 3'd6; scan[3] = 3'd7; scan[4] = 3'd0;

    model_reset();
    #12;
    chk("reset_seg", 16'(seg), 16'h00FF);
    chk("reset_ready", 16'(wr_ready), 16'h1);
    chk("reset_frame", 16'(frame), 16'h0);
    @(negedge clock);
    rst = 1'b0;
    mon_en = 1'b1;

    // non-digit selects stay dark
    step(3'd1); step(3'd2); step(3'd3); step(3'd0);
    step(3'd7); step(3'd0);

    // main write with dp on digit 1, ignored writes while pending
    frame_write(16'h12A4, 4'b0010);
    scan_check(8'hF9, 8'hA4, 8'h08, 8'h99);
    step(3'd0);
    chk("frame_pulse", 16'(frame), 16'h1);
    step(3'd0);
    chk("frame_held_zero", 16'(frame), 16'h0);

    // asynchronous reset while a write is pending
    step(3'd5, 1'b1, 16'h9999, 4'h0);
    step(3'd5);
    chk("pre_reset_seg", 16'(seg), 16'h00A4);
    chk("pre_reset_ready", 16'(wr_ready), 16'h0);
    mon_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_reset_seg", 16'(seg), 16'h00FF);
    chk("async_reset_ready", 16'(wr_ready), 16'h1);
    chk("async_reset_frame", 16'(frame), 16'h0);
    @(posedge clock); #1;
    chk("reset_hold_seg", 16'(seg), 16'h00FF);
    q.delete();
    model_reset();
    @(negedge clock);
    rst = 1'b0;
    mon_en = 1'b1;
    step(3'd7); step(3'd0);

    // leading-zero blanking
    frame_write(16'h0005, 4'b0000);
    scan_check(8'hFF, 8'hFF, 8'hFF, 8'h92);
    frame_write(16'h0000, 4'b0100);
    scan_check(8'hFF, 8'h40, 8'hFF, 8'hC0);

    // write on the boundary cycle lands one frame later
    step(3'd4); step(3'd5); step(3'd6); step(3'd7);
    step(3'd0, 1'b1, 16'h7777, 4'h0);
    scan_check(8'hFF, 8'h40, 8'hFF, 8'hC0);
    scan_check(8'hF8, 8'hF8, 8'hF8, 8'hF8);

    // glitch to 7 then 0
    step(3'd0); step(3'd7); step(3'd0); step(3'd0);
    chk("glitch_frame", 16'(frame), 16'h1);

    // immediate-commit instance: wr_ready low for exactly one cycle
    step(3'd7);
    step(3'd7, 1'b0, 16'h000B, 4'b0001, 1'b1);
    step(3'd7);
    chk("nc_ready_low", 16'(wr_ready2), 16'h0);
    step(3'd7);
    chk("nc_ready_back", 16'(wr_ready2), 16'h1);
    chk("nc_seg_old", 16'(seg2), 16'h00C0);
    chk("nc_frame", 16'(frame2), 16'h0);
    step(3'd7);
    chk("nc_seg_new", 16'(seg2), 16'h0003);

    // randomized scanning and writes
    pos = 0;
    last_s = 3'd7;
    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) s = 3'($urandom_range(0, 7));
      else if (r == 1) s = last_s;
      else begin
        s = scan[pos];
        pos = (pos + 1) % 5;
      end
      last_s = s;
      d = 16'($urandom);
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, 1) == 0) d[4*k +: 4] = 4'h0;
      dp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step(s, ($urandom_range(0, 3) == 0), d, dp);
    end
    step(3'd0);
    @(posedge clock); #2;
    chk("scoreboard_drained", 16'(q.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
